// File: rtl/accum_feeder.sv
// rtl/accum_feeder.sv - FIFO-buffered burst issuer feeding the 4-bit add-accumulate block
module accum_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int LEN_W = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             hold,
  input  logic             flush,
  output logic [WIDTH-1:0] data,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      fifo_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             enable_q, enable_d;
  logic             done_q, done_d;
  logic             push, pop;

  // Both handshakes look only at registered state, so a full FIFO never
  // accepts on the strength of a same-cycle pop and there is no fall-through.
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state_q == RUN) && (count_q != '0) && !hold
                    && (remaining_q != '0) && !flush;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    if (flush) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (burst_len != '0) begin
            remaining_d = burst_len;
            state_d     = RUN;
          end else begin
            state_d = DONE;
          end
        end
        RUN: if (pop) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // done is registered off the DONE state so it lands one cycle after the last enable.
  always_comb begin
    data_d   = pop ? mem_q[rd_ptr_q] : data_q;
    enable_d = pop;
    done_d   = (state_q == DONE) && !flush;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_q   <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      data_q   <= data_d;
      enable_q <= enable_d;
      done_q   <= done_d;
    end
  end

  assign data       = data_q;
  assign enable     = enable_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);
  assign fifo_count = count_q;

endmodule
